// File: rtl/part2_pkg.sv
// Shared types and ARF control encodings for the fetch sequencer.
// The ARF register file is external; only its select/function codes live here.
package part2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SEL,
        REQ_HI,
        INC_HI,
        SETTLE,
        REQ_LO,
        INC_LO,
        DONE,
        ERR
    } state_e;

    localparam logic [1:0] OUTSEL_PC   = 2'b11;
    localparam logic [1:0] FUN_NOP     = 2'b00;
    localparam logic [1:0] FUN_INC     = 2'b10;
    localparam logic [2:0] RSEL_PC_INC = 3'b100;
    localparam logic [2:0] RSEL_NONE   = 3'b000;

endpackage

// File: rtl/part2_wait_timer.sv
// Memory-ready wait counter: cleared outside a request, counts stalled cycles,
// and flags the stalled cycle that would bring the count to MAX_WAIT.
module part2_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = en_i && (cnt_q == CW'(MAX_WAIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/part2_fetch_sequencer.sv
// Two-byte instruction fetch: reads big-endian bytes at PC and PC+1 through the
// ARF, bumping PC after each byte and waiting one settle cycle for OutA to follow.
module part2_fetch_sequencer
    import part2_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     pc_addr,
    output logic [1:0]            arf_outasel,
    output logic [1:0]            arf_funsel,
    output logic [2:0]            arf_rsel,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  mem_ready,
    output logic [2*DATA_W-1:0]   ir,
    output logic                  ir_valid,
    output logic                  busy,
    output logic                  fetch_err
);

    state_e              state_q, state_d;
    logic [2*DATA_W-1:0] ir_q, ir_d;
    logic                in_req;
    logic                wait_en;
    logic                wait_expired;

    assign in_req  = (state_q == REQ_HI) || (state_q == REQ_LO);
    assign wait_en = in_req && !mem_ready;
    assign ir      = ir_q;

    part2_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!in_req),
        .en_i      (wait_en),
        .expired_o (wait_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        arf_outasel = OUTSEL_PC;
        arf_funsel  = FUN_NOP;
        arf_rsel    = RSEL_NONE;
        mem_rd      = 1'b0;
        mem_addr    = '0;
        ir_valid    = 1'b0;
        busy        = 1'b1;
        fetch_err   = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = SEL;
            end
            SEL: state_d = REQ_HI;
            REQ_HI: begin
                mem_rd   = 1'b1;
                mem_addr = pc_addr;
                if (mem_ready) begin
                    ir_d[2*DATA_W-1:DATA_W] = mem_data;
                    state_d                 = INC_HI;
                end else if (wait_expired) begin
                    state_d = ERR;
                end
            end
            INC_HI: begin
                arf_funsel = FUN_INC;
                arf_rsel   = RSEL_PC_INC;
                state_d    = SETTLE;
            end
            // OutA still shows the old PC here; the low-byte request must wait a cycle.
            SETTLE: state_d = REQ_LO;
            REQ_LO: begin
                mem_rd   = 1'b1;
                mem_addr = pc_addr;
                if (mem_ready) begin
                    ir_d[DATA_W-1:0] = mem_data;
                    state_d          = INC_LO;
                end else if (wait_expired) begin
                    state_d = ERR;
                end
            end
            INC_LO: begin
                arf_funsel = FUN_INC;
                arf_rsel   = RSEL_PC_INC;
                state_d    = DONE;
            end
            DONE: begin
                ir_valid = 1'b1;
                state_d  = IDLE;
            end
            ERR: begin
                busy      = 1'b0;
                fetch_err = 1'b1;
                if (start) state_d = SEL;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
